// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch stage.
//   NOP              - instruction word inserted for pipeline bubbles
//   DEFAULT_RESET_PC - PC loaded on reset
//   DEFAULT_IMEM_AW  - instruction-memory word-index width
//   if_id_t          - IF/ID pipeline register payload, shared with decode
package fetch_pkg;

  localparam int unsigned XLEN            = 32;
  localparam logic [31:0] NOP             = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_IMEM_AW = 11;
  localparam logic [31:0] PC_STEP         = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  // IF/ID payload for an empty slot
  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP, pc4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: program-counter register and next-PC selection.
//   clk, rst_n      - clock, asynchronous active-low reset
//   stall_i         - hold the PC
//   redirect_i      - load the redirect target (overrides stall_i)
//   redirect_pc_i   - redirect byte address; low two bits are dropped
//   pc_o            - current PC (word aligned)
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Byte-offset bits of the target are meaningless for word fetch
  logic [1:0] unused_redirect_lo;
  assign unused_redirect_lo = redirect_pc_i[1:0];

  // Next PC: redirect target, hold on stall, else sequential (wraps mod 2^32)
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (!stall_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage with a synchronous-read imem.
//   clk, rst_n          - clock, asynchronous active-low reset
//   stall_i             - decode cannot accept; hold the fetch pipeline
//   redirect_i          - branch/jump taken; load redirect_pc_i
//   redirect_pc_i       - redirect byte address (bits [1:0] ignored)
//   imem_addr_o         - word index to instruction memory
//   imem_instr_i        - memory data, one edge after imem_addr_o
//   if_id_instr_o       - IF/ID instruction
//   if_id_pc4_o         - IF/ID PC+4
//   if_id_valid_o       - IF/ID holds a real instruction
//   perf_fetch_cnt_o    - instructions delivered     (FETCH_PERF_EN only)
//   perf_stall_cnt_o    - stall cycles               (FETCH_PERF_EN only)
// Optional feature macro: FETCH_PERF_EN adds the two performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_AW  = DEFAULT_IMEM_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_instr_i,
  output logic [XLEN-1:0] if_id_instr_o,
  output logic [XLEN-1:0] if_id_pc4_o,
  output logic            if_id_valid_o
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetch_cnt_o,
  output logic [XLEN-1:0] perf_stall_cnt_o
`endif
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] f_pc_q,    f_pc_d;
  logic            f_valid_q, f_valid_d;
  if_id_t          if_id_q,   if_id_d;
  logic [XLEN-1:0] sel_pc;
  logic            hold;
  logic            advance;

  assign hold    = stall_i && !redirect_i;
  assign advance = !stall_i && !redirect_i;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc)
  );

  // While held, re-read the in-flight word so imem_instr_i stays valid
  assign sel_pc      = hold ? f_pc_q : pc;
  assign imem_addr_o = XLEN'(sel_pc[IMEM_AW+1:2]);

  // Bits outside the memory index are dropped: addresses wrap within imem
  logic unused_sel_pc_bits;
  assign unused_sel_pc_bits = ^{sel_pc[XLEN-1:IMEM_AW+2], sel_pc[1:0]};

  // f_valid is the only control state: 0 = refilling after redirect/reset
  always_comb begin
    f_pc_d    = f_pc_q;
    f_valid_d = f_valid_q;
    if_id_d   = if_id_q;
    if (redirect_i) begin
      f_pc_d    = pc;
      f_valid_d = 1'b0;
      if_id_d   = IF_ID_BUBBLE;
    end else if (!stall_i) begin
      f_pc_d    = pc;
      f_valid_d = 1'b1;
      if (f_valid_q) begin
        if_id_d = '{instr: imem_instr_i, pc4: f_pc_q + PC_STEP, valid: 1'b1};
      end else begin
        if_id_d = IF_ID_BUBBLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pc_q    <= '0;
      f_valid_q <= 1'b0;
      if_id_q   <= IF_ID_BUBBLE;
    end else begin
      f_pc_q    <= f_pc_d;
      f_valid_q <= f_valid_d;
      if_id_q   <= if_id_d;
    end
  end

  assign if_id_instr_o = if_id_q.instr;
  assign if_id_pc4_o   = if_id_q.pc4;
  assign if_id_valid_o = if_id_q.valid;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] perf_fetch_q, perf_fetch_d;
  logic [XLEN-1:0] perf_stall_q, perf_stall_d;

  // Count valid IF/ID loads and held cycles; both wrap mod 2^32
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (advance && f_valid_q) begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end
    if (hold) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_q;
  assign perf_stall_cnt_o = perf_stall_q;
`else
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed bench for fetch_stage against a
// queue-based model of the fetch pipeline (one in-flight fetch slot).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_instr_i  (imem_instr),
    .if_id_instr_o (if_id_instr),
    .if_id_pc4_o   (if_id_pc4),
    .if_id_valid_o (if_id_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt),
    .perf_stall_cnt_o (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory, 2048 words
  logic [31:0] mem [0:2047];
  always @(posedge clk) imem_instr <= mem[imem_addr[10:0]];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_q[$];          // byte addresses fetched but not yet delivered
  logic [31:0] e_instr, e_pc4;
  logic        e_valid;
  logic [31:0] m_fetch, m_stall;

  function automatic logic [31:0] widx(input logic [31:0] a);
    return {21'h0, a[12:2]};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    m_q.delete();
    e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
    m_fetch = 32'h0; m_stall = 32'h0;
  endtask

  task automatic model_edge(input logic st, input logic rd, input logic [31:0] rpc);
    logic [31:0] a;
    if (rd) begin
      m_q.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
      e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
    end else if (st) begin
      m_stall = m_stall + 32'd1;
    end else begin
      if (m_q.size() > 0) begin
        a = m_q.pop_front();
        e_instr = mem[widx(a)];
        e_pc4   = a + 32'd4;
        e_valid = 1'b1;
        m_fetch = m_fetch + 32'd1;
      end else begin
        e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
      end
      m_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Compare process: registered outputs are stable at the falling edge
  always @(negedge clk) begin
    chk("if_id_instr", if_id_instr, e_instr);
    chk("if_id_pc4", if_id_pc4, e_pc4);
    chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, e_valid});
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, m_fetch);
    chk("perf_stall", perf_stall_cnt, m_stall);
`endif
  end

  // One clock: drive inputs, check the combinational address, take the edge
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    stall = st; redirect = rd; redirect_pc = rpc;
    #1;
    if (!(st && !rd)) chk("imem_addr", imem_addr, widx(m_pc));
    else if (m_q.size() > 0) chk("imem_addr_hold", imem_addr, widx(m_q[0]));
    @(posedge clk); #1;
    model_edge(st, rd, rpc);
  endtask

  task automatic do_reset(input bit random_mem);
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif
    for (int i = 0; i < 2048; i++) mem[i] = random_mem ? $urandom : 32'(i + 100);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model_reset();
    for (int i = 0; i < 2048; i++) mem[i] = 32'(i + 100);
    do_reset(1'b0);

    // Free run: first delivery on edge 2
    step(1'b0, 1'b0, 32'h0);
    chk("lit_edge1_valid", {31'h0, if_id_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("lit_i0_instr", if_id_instr, 32'd100);
    chk("lit_i0_pc4", if_id_pc4, 32'd4);
    step(1'b0, 1'b0, 32'h0);
    chk("lit_i1_instr", if_id_instr, 32'd101);

    // Three-cycle stall holding instr 101
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("lit_stall_instr", if_id_instr, 32'd101);
      chk("lit_stall_pc4", if_id_pc4, 32'd8);
      chk("lit_stall_addr", imem_addr, 32'd2);
    end
    step(1'b0, 1'b0, 32'h0);
    chk("lit_after_stall", if_id_instr, 32'd102);
    chk("lit_after_stall_pc4", if_id_pc4, 32'd12);

    // Redirect to 0x40: two bubbles then mem[16]
    step(1'b0, 1'b1, 32'h40);
    chk("lit_redir_b1", {31'h0, if_id_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("lit_redir_b2", {31'h0, if_id_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("lit_redir_instr", if_id_instr, 32'd116);
    chk("lit_redir_pc4", if_id_pc4, 32'h44);

    // Redirect with stall to 0x23 -> 0x20, then stall holds the refill
    step(1'b1, 1'b1, 32'h23);
    step(1'b1, 1'b0, 32'h0);
    chk("lit_refill_hold", {31'h0, if_id_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("lit_rs_instr", if_id_instr, 32'd108);
    chk("lit_rs_pc4", if_id_pc4, 32'h24);

    // Address wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("lit_wrap_a", if_id_instr, 32'd2146);
    step(1'b0, 1'b0, 32'h0);
    chk("lit_wrap_pc4", if_id_pc4, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("lit_wrap_b", if_id_instr, 32'd100);

    // Mid-stream asynchronous reset, then 10 free + 3 stall cycles
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0);
    chk("lit_restart_instr", if_id_instr, 32'd108);
`ifdef FETCH_PERF_EN
    chk("lit_perf_stall", perf_stall_cnt, 32'd3);
    chk("lit_perf_fetch", perf_fetch_cnt, 32'd9);
`endif

    // Randomized traffic over random memory contents
    do_reset(1'b1);
    for (int n = 0; n < 3000; n++) begin
      logic        st, rd;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 12);
      rpc = $urandom;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      step(st, rd, rpc);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
